// File: rtl/syn_mem_arb_pkg.sv
// Shared types for the syn_mem arbiter: FSM states and port tags.
package syn_mem_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with its priority pointer.
module rr_arb2
  import syn_mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    ptr_d   = ptr_q;
    if (en_i) begin
      gnt_a_o = req_a_i & (~req_b_i | (ptr_q == PORT_A));
      gnt_b_o = req_b_i & (~req_a_i | (ptr_q == PORT_B));
    end
    // Pointer always lands on the port that just lost out.
    if (gnt_a_o) ptr_d = PORT_B;
    if (gnt_b_o) ptr_d = PORT_A;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= PORT_A;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/syn_mem_arbiter.sv
// Round-robin arbiter/sequencer for a single-port syn_mem.
// Define SYN_MEM_ARB_CLEAR_EN to zero the array after reset.
module syn_mem_arbiter
  import syn_mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 4,
  parameter int WORD_SIZE = 8
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_a_req,
  input  logic                 I_a_wen,
  input  logic [ADDR_SIZE-1:0] I_a_addr,
  input  logic [WORD_SIZE-1:0] I_a_wdata,
  input  logic                 I_b_req,
  input  logic                 I_b_wen,
  input  logic [ADDR_SIZE-1:0] I_b_addr,
  input  logic [WORD_SIZE-1:0] I_b_wdata,
  output logic                 O_a_gnt,
  output logic                 O_b_gnt,
  output logic                 O_a_rvalid,
  output logic                 O_b_rvalid,
  output logic [WORD_SIZE-1:0] O_a_rdata,
  output logic [WORD_SIZE-1:0] O_b_rdata,
  output logic                 O_mem_wen,
  output logic [ADDR_SIZE-1:0] O_mem_addr,
  output logic [WORD_SIZE-1:0] O_mem_wdata,
  input  logic [WORD_SIZE-1:0] I_mem_rdata,
  output logic                 O_busy
);

  logic                 clr_act;
  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 arb_en;
  logic                 gnt_a, gnt_b;

`ifdef SYN_MEM_ARB_CLEAR_EN
  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
        if (&cnt_q) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_act  = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;
`else
  assign clr_act  = 1'b0;
  assign clr_addr = '0;
`endif

  // No grant may escape while reset is held, even without a clear phase.
  assign arb_en = ~clr_act & I_rst_n;
  assign O_busy = clr_act;

  rr_arb2 u_arb (
    .clk_i   (I_clk),
    .rst_ni  (I_rst_n),
    .en_i    (arb_en),
    .req_a_i (I_a_req),
    .req_b_i (I_b_req),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign O_a_gnt = gnt_a;
  assign O_b_gnt = gnt_b;

  logic                 wen_q, wen_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 v1_q, v1_d, v2_q;
  logic                 t1_q, t1_d, t2_q;

  always_comb begin
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    v1_d    = 1'b0;
    t1_d    = t1_q;
    unique case (1'b1)
      clr_act: begin
        wen_d   = 1'b1;
        addr_d  = clr_addr;
        wdata_d = '0;
      end
      gnt_a: begin
        wen_d   = I_a_wen;
        addr_d  = I_a_addr;
        wdata_d = I_a_wdata;
        v1_d    = ~I_a_wen;
        t1_d    = PORT_A;
      end
      gnt_b: begin
        wen_d   = I_b_wen;
        addr_d  = I_b_addr;
        wdata_d = I_b_wdata;
        v1_d    = ~I_b_wen;
        t1_d    = PORT_B;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      t1_q    <= PORT_A;
      t2_q    <= PORT_A;
    end else begin
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      v1_q    <= v1_d;
      v2_q    <= v1_q;
      t1_q    <= t1_d;
      t2_q    <= t1_q;
    end
  end

  assign O_mem_wen   = wen_q;
  assign O_mem_addr  = addr_q;
  assign O_mem_wdata = wdata_q;

  assign O_a_rvalid = v2_q & (t2_q == PORT_A);
  assign O_b_rvalid = v2_q & (t2_q == PORT_B);
  assign O_a_rdata  = I_mem_rdata;
  assign O_b_rdata  = I_mem_rdata;

endmodule

// File: doc/syn_mem_arbiter.md
# syn_mem_arbiter

Two-requester round-robin arbiter and sequencer for a single-port `syn_mem` instance (write on clock edge, registered read data). It sits between the PUF response writer (port A) and the readout/host interface (port B). It accepts at most one memory command per cycle, drives the memory, and routes read data back to the requester that issued the read. An optional post-reset clear engine zeroes the array before any request is granted.

## Interface
- `ADDR_SIZE`, 4, memory address width; the array holds 2^ADDR_SIZE words.
- `WORD_SIZE`, 8, data word width.

- `I_clk`  in  1  clock; all state updates on the rising edge.
- `I_rst_n`  in  1  reset, asynchronous, active-low.
- `I_a_req` / `I_b_req`  in  1  request; held high with stable command until granted.
- `I_a_wen` / `I_b_wen`  in  1  1 = write, 0 = read.
- `I_a_addr` / `I_b_addr`  in  ADDR_SIZE  command address.
- `I_a_wdata` / `I_b_wdata`  in  WORD_SIZE  write data.
- `O_a_gnt` / `O_b_gnt`  out  1  combinational; high in the cycle the command is accepted.
- `O_a_rvalid` / `O_b_rvalid`  out  1  read data valid for this port, one-cycle pulse.
- `O_a_rdata` / `O_b_rdata`  out  WORD_SIZE  read data; equals `I_mem_rdata`, meaningful only while the matching rvalid is high.
- `O_mem_wen`  out  1  registered memory write enable.
- `O_mem_addr`  out  ADDR_SIZE  registered memory address.
- `O_mem_wdata`  out  WORD_SIZE  registered memory write data.
- `I_mem_rdata`  in  WORD_SIZE  memory `O_data`.
- `O_busy`  out  1  high while the clear sequence runs.

## Operation
- States: CLEAR and ARB. Reset enters CLEAR when clear is compiled in, otherwise ARB.
- CLEAR
  - `O_mem_wen`=1, `O_mem_wdata`=0, `O_mem_addr` counts 0 up to 2^ADDR_SIZE-1, one address per cycle.
  - Both gnt outputs stay 0.
  - After the last address is issued, go to ARB.
- ARB arbitration
  - Exactly one requester high: that requester is granted.
  - Both high: grant goes to the port named by the priority pointer.
  - After every grant, the pointer moves to the other port. Reset value of the pointer is A.
  - Each grant loads the command into the `O_mem_*` registers at the clock edge.
  - No grant: `O_mem_wen`=0 and `O_mem_addr`/`O_mem_wdata` hold their values.
- Read tracking
  - Each accepted read pushes a port tag into a 2-stage tag/valid pipeline.
  - The stage-2 valid drives the rvalid of the tagged port.
  - Back-to-back accepts every cycle are allowed with no bubbles.
- Ordering
  - A read accepted the cycle after a write to the same address returns the new data.
  - Commands execute in grant order.
- Reset during operation
  - Reset mid-CLEAR restarts the clear from address 0.
  - Reset drops any in-flight reads; no rvalid is asserted for them.
- Reset values
  - gnt, rvalid, `O_mem_wen`, `O_mem_addr`, `O_mem_wdata` are all 0.
  - `O_busy` is 1 if clear is compiled in, else 0.
  - Pointer is A.

## Timing
- Cycle 0: gnt high.
- Edge E0: command registered onto the `O_mem_*` outputs.
- Edge E1: memory performs the write or latches the read.
- Cycle after E1 (cycle 2): rvalid high with data. Read latency is therefore 2 cycles from gnt.
- Write has no response. A write is complete at E1.
- `O_busy` is high from reset release for exactly 2^ADDR_SIZE cycles. The first gnt can occur in the cycle `O_busy` falls.

## Configuration
- `SYN_MEM_ARB_CLEAR_EN` defined:
  - CLEAR state, clear counter and `O_busy` logic are present.
  - The array reads 0 everywhere after reset.
- Not defined:
  - Reset enters ARB directly.
  - `O_busy` is tied to 0.
  - Memory contents after reset are undefined.

## Structure
- Package `syn_mem_arb_pkg` holds:
  - state encoding (`ST_CLEAR`, `ST_ARB`);
  - port tag constants (`PORT_A`=0, `PORT_B`=1).
- Sub-module `rr_arb2`: two-input round-robin grant logic plus the priority pointer register.
- Top level holds the FSM, clear counter, command registers and tag pipeline.

## Test plan
(ADDR_SIZE=4, WORD_SIZE=8, backed by a real `syn_mem` instance.)
- Clear: release reset with the macro defined; hold `I_b_req`=1 (read, addr 7).
  - `O_busy` stays high for 16 cycles with no gnt, then `O_b_gnt` goes high.
  - `O_b_rvalid` fires 2 cycles later with data 0x00.
- Single-port traffic:
  - A writes data i+1 to addr i for i=0..9, one per cycle; gnt is high every cycle.
  - A then reads addr 0..9, one per cycle; rvalid returns 1..10 on consecutive cycles.
- Contention: A and B both request continuously, with A first after reset.
  - Grants alternate A,B,A,B.
  - Each rvalid pulse appears only on the issuing port, with correct data.
- Read-after-write: A writes 0x5A to addr 3; B reads addr 3 in the next cycle.
  - `O_b_rdata`=0x5A at B's rvalid.
- Reset mid-clear: assert `I_rst_n`=0 at clear address 9, then release.
  - Clear restarts at addr 0 and `O_busy` lasts a full 16 cycles.
- Reset with a read in flight: assert reset one cycle after a read gnt.
  - No rvalid is asserted.
  - All outputs return to their reset values immediately.
